regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port (write enable, 5-bit write address, 32-bit write data) between two writeback requesters: the ALU result path (A) and the memory-load path (M).
- Each requester has a one-entry holding slot behind a valid/ready handshake.
- A round-robin arbiter moves one slot per cycle into a registered output stage, which drives the register file write port directly.
- Writes to register 0 are discarded at acceptance.

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_skid_slot.sv | 36 +++
 rtl/regfile_wb_arbiter.sv | 117 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Holds default widths, the zero-register constant and requester indices.
package wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef logic req_t;

    localparam req_t REQ_A = 1'b0;
    localparam req_t REQ_M = 1'b1;

endpackage

// File: rtl/wb_skid_slot.sv
// One-entry holding register for a writeback requester.
// A write aimed at register 0 completes the load but leaves the slot empty.
module wb_skid_slot
    import wb_pkg::*;
#(
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int ADDR_W = wb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              unload,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    // A load on the same edge as an unload refills the slot in place.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (load) begin
            full <= (load_addr != ADDR_W'(REG_ZERO));
            addr <= load_addr;
            data <= load_data;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU and load writeback.
// Optional bypass outputs for decode are built when WB_FWD_EN is defined.
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int ADDR_W = wb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_data,
`ifdef WB_FWD_EN
    input  logic [ADDR_W-1:0] rr1,
    input  logic [ADDR_W-1:0] rr2,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic              WriteReg,
    output logic [ADDR_W-1:0] WR,
    output logic [DATA_W-1:0] WD
);

    logic              a_full;
    logic              m_full;
    logic [ADDR_W-1:0] a_slot_addr;
    logic [ADDR_W-1:0] m_slot_addr;
    logic [DATA_W-1:0] a_slot_data;
    logic [DATA_W-1:0] m_slot_data;
    logic              grant_valid;
    req_t              grant_sel;
    req_t              last_grant;
    logic              a_grant;
    logic              m_grant;

    wb_skid_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_a (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .load      (a_valid && a_ready),
        .unload    (a_grant),
        .load_addr (a_addr),
        .load_data (a_data),
        .full      (a_full),
        .addr      (a_slot_addr),
        .data      (a_slot_data)
    );

    wb_skid_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_m (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .load      (m_valid && m_ready),
        .unload    (m_grant),
        .load_addr (m_addr),
        .load_data (m_data),
        .full      (m_full),
        .addr      (m_slot_addr),
        .data      (m_slot_data)
    );

    // On contention the requester that did not win last time goes first.
    always_comb begin
        grant_valid = a_full || m_full;
        grant_sel   = REQ_A;
        if (a_full && m_full) begin
            grant_sel = (last_grant == REQ_M) ? REQ_A : REQ_M;
        end else if (m_full) begin
            grant_sel = REQ_M;
        end
    end

    assign a_grant = grant_valid && (grant_sel == REQ_A);
    assign m_grant = grant_valid && (grant_sel == REQ_M);

    // Flush empties both slots, so accepting during it is always safe.
    assign a_ready = !a_full || a_grant || flush;
    assign m_ready = !m_full || m_grant || flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= REQ_M;
        end else if (!flush && grant_valid) begin
            last_grant <= grant_sel;
        end
    end

    // WR/WD hold their last value whenever no write is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            WriteReg <= 1'b0;
            WR       <= '0;
            WD       <= '0;
        end else if (flush || !grant_valid) begin
            WriteReg <= 1'b0;
        end else begin
            WriteReg <= 1'b1;
            WR       <= (grant_sel == REQ_A) ? a_slot_addr : m_slot_addr;
            WD       <= (grant_sel == REQ_A) ? a_slot_data : m_slot_data;
        end
    end

`ifdef WB_FWD_EN
    assign fwd1_hit = WriteReg && (WR == rr1) && (rr1 != ADDR_W'(REG_ZERO));
    assign fwd2_hit = WriteReg && (WR == rr2) && (rr2 != ADDR_W'(REG_ZERO));
    assign fwd_data = WD;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, streaming sequence,
// randomized traffic against a behavioural model, and the WB_FWD_EN bypass when enabled.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        WriteReg;
    logic [4:0]  WR;
    logic [31:0] WD;
`ifdef WB_FWD_EN
    logic [4:0]  rr1 = 5'd0;
    logic [4:0]  rr2 = 5'd0;
    logic        fwd1_hit;
    logic        fwd2_hit;
    logic [31:0] fwd_data;
`endif

    int total = 0;
    int bad   = 0;

    regfile_wb_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_addr   (m_addr),
        .m_data   (m_data),
`ifdef WB_FWD_EN
        .rr1      (rr1),
        .rr2      (rr2),
        .fwd1_hit (fwd1_hit),
        .fwd2_hit (fwd2_hit),
        .fwd_data (fwd_data),
`endif
        .WriteReg (WriteReg),
        .WR       (WR),
        .WD       (WD)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        ea;
        logic        em;
        logic        ewe;
        logic [4:0]  ewr;
        logic [31:0] ewd;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic r, input logic f,
                                input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic mv, input logic [4:0] ma, input logic [31:0] md,
                                input logic ea, input logic em, input logic ewe,
                                input logic [4:0] ewr, input logic [31:0] ewd);
        vec_t v;
        v.rst = r;   v.flush = f;
        v.av  = av;  v.aa = aa;  v.ad = ad;
        v.mv  = mv;  v.ma = ma;  v.md = md;
        v.ea  = ea;  v.em = em;  v.ewe = ewe;  v.ewr = ewr;  v.ewd = ewd;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic ea, input logic em,
                               input logic ewe, input logic [4:0] ewr, input logic [31:0] ewd);
        checkVal({tag, ".a_ready"},  a_ready,  ea);
        checkVal({tag, ".m_ready"},  m_ready,  em);
        checkVal({tag, ".WriteReg"}, WriteReg, ewe);
        checkVal({tag, ".WR"},       WR,       ewr);
        checkVal({tag, ".WD"},       WD,       ewd);
    endtask

    task automatic applyStimulus(input vec_t v);
        rst     = v.rst;
        flush   = v.flush;
        a_valid = v.av;
        a_addr  = v.aa;
        a_data  = v.ad;
        m_valid = v.mv;
        m_addr  = v.ma;
        m_data  = v.md;
    endtask

    task automatic resetDut();
        @(negedge clk);
        applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(posedge clk);
    endtask

    // Behavioural model state for the randomized phase
    logic        mdl_full [2];
    logic [4:0]  mdl_addr [2];
    logic [31:0] mdl_data [2];
    int          mdl_last;
    logic        o_we;
    logic [4:0]  o_wr;
    logic [31:0] o_wd;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [4:0]  obs_wr [32];
        logic [31:0] obs_wd [32];
        int nwr, ka, km, cyc;
        logic la, lm;

        // Directed table; each row: inputs for a cycle, expectations sampled before its edge
        vecs[0]  = mk(0,0, 0,0,0,             0,0,0,            1,1,0, 0,0);
        vecs[1]  = mk(0,0, 1,8,32'h1234_5678, 0,0,0,            1,1,0, 0,0);
        vecs[2]  = mk(0,0, 0,0,0,             0,0,0,            1,1,0, 0,0);
        vecs[3]  = mk(0,0, 0,0,0,             0,0,0,            1,1,1, 8,32'h1234_5678);
        vecs[4]  = mk(0,0, 0,0,0,             0,0,0,            1,1,0, 8,32'h1234_5678);
        vecs[5]  = mk(1,0, 0,0,0,             0,0,0,            1,1,0, 8,32'h1234_5678);
        vecs[6]  = mk(0,0, 1,3,32'hA,         1,4,32'hB,        1,1,0, 0,0);
        vecs[7]  = mk(0,0, 0,0,0,             0,0,0,            1,0,0, 0,0);
        vecs[8]  = mk(0,0, 0,0,0,             0,0,0,            1,1,1, 3,32'hA);
        vecs[9]  = mk(0,0, 0,0,0,             0,0,0,            1,1,1, 4,32'hB);
        vecs[10] = mk(0,0, 0,0,0,             0,0,0,            1,1,0, 4,32'hB);
        vecs[11] = mk(0,0, 1,0,32'hDEAD,      0,0,0,            1,1,0, 4,32'hB);
        vecs[12] = mk(0,0, 0,0,0,             0,0,0,            1,1,0, 4,32'hB);
        vecs[13] = mk(0,0, 0,0,0,             0,0,0,            1,1,0, 4,32'hB);
        vecs[14] = mk(0,0, 1,5,32'h55,        1,6,32'h66,       1,1,0, 4,32'hB);
        vecs[15] = mk(0,1, 1,9,32'h99,        0,0,0,            1,1,0, 4,32'hB);
        vecs[16] = mk(0,0, 0,0,0,             0,0,0,            1,1,0, 4,32'hB);
        vecs[17] = mk(0,0, 0,0,0,             0,0,0,            1,1,0, 4,32'hB);
        vecs[18] = mk(0,0, 0,0,0,             0,0,0,            1,1,0, 4,32'hB);
        vecs[19] = mk(0,0, 1,10,32'h1010,     1,11,32'h1111,    1,1,0, 4,32'hB);
        vecs[20] = mk(1,0, 0,0,0,             0,0,0,            1,0,0, 4,32'hB);
        vecs[21] = mk(0,0, 0,0,0,             0,0,0,            1,1,0, 0,0);
        vecs[22] = mk(0,0, 0,0,0,             0,0,0,            1,1,0, 0,0);

        resetDut();
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d", i), vecs[i].ea, vecs[i].em,
                        vecs[i].ewe, vecs[i].ewr, vecs[i].ewd);
        end

        // Streaming: both requesters always valid, expect strict A/M alternation
        resetDut();
        ka = 0; km = 0; nwr = 0; cyc = 0;
        while ((ka < 8 || km < 8) && cyc < 40) begin
            @(negedge clk);
            rst = 0; flush = 0;
            a_valid = (ka < 8); a_addr = 5'd1; a_data = 32'hA000_0000 + 32'(ka);
            m_valid = (km < 8); m_addr = 5'd2; m_data = 32'hB000_0000 + 32'(km);
            #1;
            if (WriteReg && nwr < 32) begin
                obs_wr[nwr] = WR; obs_wd[nwr] = WD; nwr++;
            end
            la = a_valid && a_ready;
            lm = m_valid && m_ready;
            @(posedge clk);
            if (la) ka++;
            if (lm) km++;
            cyc++;
        end
        for (int d = 0; d < 6; d++) begin
            @(negedge clk);
            a_valid = 0; m_valid = 0;
            #1;
            if (WriteReg && nwr < 32) begin
                obs_wr[nwr] = WR; obs_wd[nwr] = WD; nwr++;
            end
        end
        checkVal("stream.a_accepts", 32'(ka), 32'd8);
        checkVal("stream.m_accepts", 32'(km), 32'd8);
        checkVal("stream.within16", 32'(cyc <= 16), 32'd1);
        checkVal("stream.writes", 32'(nwr), 32'd16);
        for (int i = 0; i < 16 && i < nwr; i++) begin
            checkVal($sformatf("stream.wr%0d", i), obs_wr[i], (i % 2 == 0) ? 32'd1 : 32'd2);
            checkVal($sformatf("stream.wd%0d", i), obs_wd[i],
                     ((i % 2 == 0) ? 32'hA000_0000 : 32'hB000_0000) + 32'(i / 2));
        end

`ifdef WB_FWD_EN
        resetDut();
        @(negedge clk);
        rst = 0; flush = 0; m_valid = 0;
        a_valid = 1; a_addr = 5'd7; a_data = 32'hCAFE;
        rr1 = 5'd7; rr2 = 5'd0;
        #1;
        checkVal("fwd.idle_hit1", fwd1_hit, 1'b0);
        @(negedge clk);
        a_valid = 0;
        @(negedge clk);
        #1;
        checkVal("fwd.WriteReg", WriteReg, 1'b1);
        checkVal("fwd.hit1", fwd1_hit, 1'b1);
        checkVal("fwd.hit2", fwd2_hit, 1'b0);
        checkVal("fwd.data", fwd_data, 32'hCAFE);
        @(negedge clk);
        #1;
        checkVal("fwd.after_hit1", fwd1_hit, 1'b0);
        rr1 = 5'd0;
`endif

        // Randomized traffic checked against the behavioural model
        resetDut();
        mdl_full[0] = 0; mdl_full[1] = 0;
        mdl_addr[0] = 0; mdl_addr[1] = 0;
        mdl_data[0] = 0; mdl_data[1] = 0;
        mdl_last = 1;
        o_we = 0; o_wr = 0; o_wd = 0;
        for (int c = 0; c < 300; c++) begin
            logic        vld [2];
            logic [4:0]  adr [2];
            logic [31:0] dat [2];
            logic        rdy [2];
            int          g;
            @(negedge clk);
            rst     = 0;
            flush   = ($urandom_range(0, 15) == 0);
            a_valid = ($urandom_range(0, 2) != 0);
            a_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            a_data  = $urandom;
            m_valid = ($urandom_range(0, 2) != 0);
            m_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            m_data  = $urandom;
            #1;
            vld[0] = a_valid; adr[0] = a_addr; dat[0] = a_data;
            vld[1] = m_valid; adr[1] = m_addr; dat[1] = m_data;
            if (mdl_full[0] && mdl_full[1]) g = 1 - mdl_last;
            else if (mdl_full[0])           g = 0;
            else if (mdl_full[1])           g = 1;
            else                            g = -1;
            for (int r = 0; r < 2; r++) rdy[r] = !mdl_full[r] || (g == r) || flush;
            checkOutput($sformatf("rand%0d", c), rdy[0], rdy[1], o_we, o_wr, o_wd);
            @(posedge clk);
            if (flush) begin
                mdl_full[0] = 0; mdl_full[1] = 0;
                o_we = 0;
            end else begin
                if (g >= 0) begin
                    o_we = 1; o_wr = mdl_addr[g]; o_wd = mdl_data[g];
                    mdl_full[g] = 0;
                    mdl_last = g;
                end else begin
                    o_we = 0;
                end
                for (int r = 0; r < 2; r++) begin
                    if (vld[r] && rdy[r]) begin
                        mdl_full[r] = (adr[r] != 5'd0);
                        mdl_addr[r] = adr[r];
                        mdl_data[r] = dat[r];
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
